// File: rtl/msj_pd_update_scheduler_if.sv
// Start/done handshake between the update scheduler and the shared PD arithmetic unit.
interface msj_pd_update_scheduler_if #(
    parameter int IDX_WIDTH = 4
);
    logic                 pd_start_o;
    logic [IDX_WIDTH-1:0] pd_index_o;
    logic                 pd_done_i;

    // Handshake: the master raises pd_start_o for one cycle with pd_index_o valid; pd_index_o
    // stays stable until the slave returns a one-cycle pd_done_i or the master times out.
    // The slave may not assert pd_done_i in the start cycle itself; such a strobe is ignored.
    modport master (output pd_start_o, output pd_index_o, input pd_done_i);
    modport slave  (input pd_start_o, input pd_index_o, output pd_done_i);
endinterface

// File: rtl/msj_pd_update_scheduler.sv
// Round-robin scheduler sharing one PD datapath across motor channels; latches PWM duty on
// completion and records timeouts and dropped (overrun) requests.
module msj_pd_update_scheduler #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int IDX_WIDTH        = 4,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUMBER_OF_MOTORS-1:0] cycle_i,
    input  logic [NUMBER_OF_MOTORS-1:0] force_update_i,
    input  logic [NUMBER_OF_MOTORS-1:0] enable_mask_i,
    input  logic                        clear_status_i,
    msj_pd_update_scheduler_if.master   pd_if,
    output logic [NUMBER_OF_MOTORS-1:0] latch_pwm_o,
    output logic [NUMBER_OF_MOTORS-1:0] pending_o,
    output logic                        busy_o,
    output logic [NUMBER_OF_MOTORS-1:0] timeout_flags_o,
    output logic [15:0]                 overrun_count_o,
    output logic [1:0]                  state_o
);
    localparam int N     = NUMBER_OF_MOTORS;
    localparam int SW    = IDX_WIDTH + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [N-1:0]         pending_q, pending_d;
    logic [IDX_WIDTH-1:0] pd_index_q, pd_index_d;
    logic [IDX_WIDTH-1:0] last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 start_q, start_d;
    logic [N-1:0]         latch_q, latch_d;
    logic [N-1:0]         tflags_q, tflags_d;
    logic [15:0]          ovr_q, ovr_d;

    logic [N-1:0]         req, eligible, clr, tmo_set, ovr_vec, rr_sh;
    logic [SW-1:0]        rr_sum;
    logic                 grant_vld;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic [16:0]          ovr_sum;

    assign req      = (cycle_i | force_update_i) & enable_mask_i;
    assign eligible = pending_q & enable_mask_i;

    // Walk downward so the candidate closest after last_q is the final (winning) assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        rr_sh     = '0;
        for (int k = N; k >= 1; k--) begin
            rr_sum = {1'b0, last_q} + SW'(k);
            if (rr_sum >= SW'(N)) rr_sum = rr_sum - SW'(N);
            rr_sh = eligible >> rr_sum[IDX_WIDTH-1:0];
            if (rr_sh[0]) begin
                grant_vld = 1'b1;
                grant_idx = rr_sum[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pd_index_d = pd_index_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        start_d    = 1'b0;
        latch_d    = '0;
        tmo_set    = '0;
        clr        = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    clr        = N'(1) << grant_idx;
                    pd_index_d = grant_idx;
                    start_d    = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pd_if.pd_done_i) begin
                    latch_d = N'(1) << pd_index_q;
                    state_d = S_COMMIT;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_set = N'(1) << pd_index_q;
                    last_d  = pd_index_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_COMMIT: begin
                last_d  = pd_index_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A request coinciding with its own grant re-arms pending and is not counted as dropped.
    assign pending_d = (pending_q & ~clr & enable_mask_i) | req;
    assign ovr_vec   = req & pending_q & ~clr;
    assign ovr_sum   = {1'b0, ovr_q} + 17'($countones(ovr_vec));

    always_comb begin
        if (clear_status_i) begin
            tflags_d = '0;
            ovr_d    = '0;
        end else begin
            tflags_d = tflags_q | tmo_set;
            ovr_d    = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            pd_index_q <= '0;
            last_q     <= IDX_WIDTH'(N - 1);
            cnt_q      <= '0;
            start_q    <= 1'b0;
            latch_q    <= '0;
            tflags_q   <= '0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            pd_index_q <= pd_index_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            latch_q    <= latch_d;
            tflags_q   <= tflags_d;
            ovr_q      <= ovr_d;
        end
    end

    assign pd_if.pd_start_o = start_q;
    assign pd_if.pd_index_o = pd_index_q;
    assign latch_pwm_o      = latch_q;
    assign pending_o        = pending_q;
    assign busy_o           = (state_q != S_IDLE);
    assign timeout_flags_o  = tflags_q;
    assign overrun_count_o  = ovr_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_msj_pd_update_scheduler.sv
// Self-checking bench for the PD update scheduler: round-robin vector table plus hand-timed
// sequences for overrun, timeout, masking and mid-operation reset.
module tb_msj_pd_update_scheduler;
    localparam int N   = 6;
    localparam int IW  = 4;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  cycle_v, force_v, en_v;
    logic          clr_st;
    logic [N-1:0]  latch, pending, tflags;
    logic          busy;
    logic [15:0]   ovr;
    logic [1:0]    st;

    msj_pd_update_scheduler_if #(.IDX_WIDTH(IW)) pd_if ();

    msj_pd_update_scheduler #(
        .NUMBER_OF_MOTORS(N),
        .IDX_WIDTH(IW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clk),
        .reset(rst),
        .cycle_i(cycle_v),
        .force_update_i(force_v),
        .enable_mask_i(en_v),
        .clear_status_i(clr_st),
        .pd_if(pd_if),
        .latch_pwm_o(latch),
        .pending_o(pending),
        .busy_o(busy),
        .timeout_flags_o(tflags),
        .overrun_count_o(ovr),
        .state_o(st)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [IW-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] req;
        int           dly;
        int           n_grants;
        logic [23:0]  order;
    } vec_t;
    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle_v = '0;
        force_v = '0;
        clr_st = 1'b0;
        pd_if.pd_done_i = 1'b0;
        en_v = '1;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (busy && w < 100) begin
            tick();
            w++;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    // driver + scoreboard pop: wait for a grant, compare index, answer after dly cycles
    task automatic serve(input int dly, input string name);
        int w;
        logic [IW-1:0] e;
        logic [N-1:0] oh;
        w = 0;
        while (!pd_if.pd_start_o && w < 40) begin
            tick();
            w++;
        end
        check({name, "_start_seen"}, 32'(pd_if.pd_start_o), 32'd1);
        if (pd_if.pd_start_o) begin
            if (exp_q.size() == 0) begin
                check({name, "_unexpected_grant"}, 32'(pd_if.pd_index_o), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check({name, "_index"}, 32'(pd_if.pd_index_o), 32'(e));
                repeat (dly) tick();
                check({name, "_index_stable"}, 32'(pd_if.pd_index_o), 32'(e));
                pd_if.pd_done_i = 1'b1;
                tick();
                pd_if.pd_done_i = 1'b0;
                oh = 6'd1 << e;
                check({name, "_latch"}, 32'(latch), 32'(oh));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst && latch != '0) begin
            n_cmp++;
            if (!$onehot(latch)) begin
                n_err++;
                $display("FAIL latch_onehot: got 0x%0h expected one bit set", latch);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic any;
        rst = 1'b1;
        cycle_v = '0;
        force_v = '0;
        en_v = '1;
        clr_st = 1'b0;
        pd_if.pd_done_i = 1'b0;

        vecs[0] = '{6'b111111, 3, 6, {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
        vecs[1] = '{6'b001010, 3, 2, {16'h0, 4'd3, 4'd1}};
        vecs[2] = '{6'b100001, 4, 2, {16'h0, 4'd0, 4'd5}};
        vecs[3] = '{6'b010110, 5, 3, {12'h0, 4'd4, 4'd2, 4'd1}};
        vecs[4] = '{6'b000001, 3, 1, {20'h0, 4'd0}};
        vecs[5] = '{6'b100100, 6, 2, {16'h0, 4'd5, 4'd2}};

        // reset state and single request timing
        do_reset();
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_latch", 32'(latch), 32'd0);
        check("rst_start", 32'(pd_if.pd_start_o), 32'd0);
        check("rst_index", 32'(pd_if.pd_index_o), 32'd0);
        check("rst_tflags", 32'(tflags), 32'd0);
        check("rst_ovr", 32'(ovr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(st), 32'd0);
        cycle_v = 6'b000100;
        tick();
        cycle_v = '0;
        check("single_pending_c1", 32'(pending), 32'h4);
        check("single_nostart_c1", 32'(pd_if.pd_start_o), 32'd0);
        tick();
        check("single_start_c2", 32'(pd_if.pd_start_o), 32'd1);
        check("single_index_c2", 32'(pd_if.pd_index_o), 32'd2);
        check("single_busy_c2", 32'(busy), 32'd1);
        check("single_pending_c2", 32'(pending), 32'd0);
        repeat (5) tick();
        check("single_nolatch_c7", 32'(latch), 32'd0);
        pd_if.pd_done_i = 1'b1;
        tick();
        pd_if.pd_done_i = 1'b0;
        check("single_latch_c8", 32'(latch), 32'h4);
        check("single_busy_c8", 32'(busy), 32'd1);
        tick();
        check("single_busy_c9", 32'(busy), 32'd0);
        check("single_latch_c9", 32'(latch), 32'd0);

        // round-robin vector table
        do_reset();
        for (int v = 0; v < 6; v++) begin
            for (int g = 0; g < vecs[v].n_grants; g++)
                exp_q.push_back(IW'((vecs[v].order >> (4 * g)) & 24'hF));
            cycle_v = vecs[v].req;
            tick();
            cycle_v = '0;
            for (int g = 0; g < vecs[v].n_grants; g++) serve(vecs[v].dly, "rr");
            wait_idle("rr");
            check("rr_queue_drained", 32'(exp_q.size()), 32'd0);
            check("rr_pending_clear", 32'(pending), 32'd0);
        end

        // overrun and same-cycle request/clear
        do_reset();
        cycle_v = 6'b010000;
        tick();
        cycle_v = '0;
        tick();
        check("ovr_index4", 32'(pd_if.pd_index_o), 32'd4);
        force_v = 6'b000001;
        repeat (4) tick();
        force_v = '0;
        check("ovr_count3", 32'(ovr), 32'd3);
        check("ovr_pending0", 32'(pending), 32'h1);
        pd_if.pd_done_i = 1'b1;
        tick();
        pd_if.pd_done_i = 1'b0;
        check("ovr_latch4", 32'(latch), 32'h10);
        tick();
        force_v = 6'b000001;
        tick();
        force_v = '0;
        check("same_cycle_pending", 32'(pending), 32'h1);
        check("same_cycle_no_ovr", 32'(ovr), 32'd3);
        check("same_cycle_start", 32'(pd_if.pd_start_o), 32'd1);
        check("same_cycle_index", 32'(pd_if.pd_index_o), 32'd0);
        clr_st = 1'b1;
        tick();
        clr_st = 1'b0;
        check("ovr_cleared", 32'(ovr), 32'd0);
        pd_if.pd_done_i = 1'b1;
        tick();
        pd_if.pd_done_i = 1'b0;
        check("same_cycle_latch0", 32'(latch), 32'h1);
        exp_q.push_back(IW'(0));
        serve(3, "regrant");
        wait_idle("ovr");

        // timeout, late done, clear, and round-robin resumes after the timed-out motor
        do_reset();
        cycle_v = 6'b000010;
        tick();
        cycle_v = '0;
        tick();
        check("tmo_start", 32'(pd_if.pd_start_o), 32'd1);
        check("tmo_index", 32'(pd_if.pd_index_o), 32'd1);
        any = 1'b0;
        for (int k = 1; k < TMO; k++) begin
            tick();
            if (latch != '0) any = 1'b1;
        end
        tick();
        check("tmo_flag_not_yet", 32'(tflags), 32'd0);
        check("tmo_still_wait", 32'(st), 32'd2);
        tick();
        if (latch != '0) any = 1'b1;
        check("tmo_no_latch", 32'(any), 32'd0);
        check("tmo_flag_set", 32'(tflags), 32'h2);
        check("tmo_idle", 32'(busy), 32'd0);
        pd_if.pd_done_i = 1'b1;
        tick();
        pd_if.pd_done_i = 1'b0;
        check("tmo_late_done_latch", 32'(latch), 32'd0);
        check("tmo_late_done_busy", 32'(busy), 32'd0);
        clr_st = 1'b1;
        tick();
        clr_st = 1'b0;
        check("tmo_flag_cleared", 32'(tflags), 32'd0);
        exp_q.push_back(IW'(2));
        exp_q.push_back(IW'(0));
        cycle_v = 6'b000101;
        tick();
        cycle_v = '0;
        serve(3, "post_tmo");
        serve(3, "post_tmo");
        wait_idle("tmo");

        // enable masking
        do_reset();
        cycle_v = 6'b010000;
        tick();
        cycle_v = '0;
        tick();
        tick();
        cycle_v = 6'b001000;
        tick();
        cycle_v = '0;
        check("mask_pending3", 32'(pending), 32'h8);
        en_v = 6'b110111;
        tick();
        check("mask_dropped", 32'(pending), 32'd0);
        cycle_v = 6'b001000;
        tick();
        tick();
        cycle_v = '0;
        check("mask_no_pending", 32'(pending), 32'd0);
        check("mask_no_ovr", 32'(ovr), 32'd0);
        pd_if.pd_done_i = 1'b1;
        tick();
        pd_if.pd_done_i = 1'b0;
        check("mask_latch4", 32'(latch), 32'h10);
        any = 1'b0;
        repeat (10) begin
            tick();
            if (pd_if.pd_start_o) any = 1'b1;
        end
        check("mask_never_granted", 32'(any), 32'd0);
        check("mask_idle", 32'(busy), 32'd0);
        en_v = '1;

        // reset in the middle of a WAIT
        do_reset();
        cycle_v = 6'b100000;
        tick();
        cycle_v = '0;
        tick();
        check("midrst_index5", 32'(pd_if.pd_index_o), 32'd5);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_state", 32'(st), 32'd0);
        check("midrst_index", 32'(pd_if.pd_index_o), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_pending", 32'(pending), 32'd0);
        check("midrst_start", 32'(pd_if.pd_start_o), 32'd0);
        pd_if.pd_done_i = 1'b1;
        tick();
        pd_if.pd_done_i = 1'b0;
        check("midrst_stray_latch", 32'(latch), 32'd0);
        check("midrst_stray_busy", 32'(busy), 32'd0);
        exp_q.push_back(IW'(0));
        exp_q.push_back(IW'(5));
        cycle_v = 6'b100001;
        tick();
        cycle_v = '0;
        serve(3, "midrst");
        serve(3, "midrst");
        wait_idle("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
